// File: rtl/rgb_led_sched.sv
// ============================================================================
// Module   : rgb_led_sched
// Purpose  : Round-robin scheduler that shares one RGB LED among three
//            requesters. Optional PWM dimming is enabled by the macro
//            RGB_LED_SCHED_PWM_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rgb_led_sched #(
    parameter int HOLD_W = 8,
    parameter int PWM_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [8:0]            req_color,
    input  logic [3*HOLD_W-1:0]   req_hold,
    input  logic [PWM_W-1:0]      duty,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic                  busy,
    output logic                  led_green,
    output logic                  led_red,
    output logic                  led_blue
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_owner;
    logic [1:0]          r_last;
    logic [2:0]          r_color;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [1:0]          w_win;
    logic                w_win_vld;
    logic                w_take;
    logic [2:0]          w_sel_color;
    logic [HOLD_W-1:0]   w_sel_hold;
    logic                w_show;
    logic                w_pwm_on;
    logic [2:0]          w_owner_onehot;

    // Scan order starts just after the previous owner, so the previous
    // owner is always considered last.
    always_comb begin
        w_win_vld = |req;
        w_win     = 2'd0;
        case (r_last)
            2'd0: begin
                if (req[1])      w_win = 2'd1;
                else if (req[2]) w_win = 2'd2;
                else             w_win = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_win = 2'd2;
                else if (req[0]) w_win = 2'd0;
                else             w_win = 2'd1;
            end
            default: begin
                if (req[0])      w_win = 2'd0;
                else if (req[1]) w_win = 2'd1;
                else             w_win = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_sel_color = req_color[2:0];
        w_sel_hold  = req_hold[HOLD_W-1:0];
        case (w_win)
            2'd1: begin
                w_sel_color = req_color[5:3];
                w_sel_hold  = req_hold[2*HOLD_W-1:HOLD_W];
            end
            2'd2: begin
                w_sel_color = req_color[8:6];
                w_sel_hold  = req_hold[3*HOLD_W-1:2*HOLD_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_win_vld) begin
                    w_next = ST_SHOW;
                    w_take = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (r_hold_cnt == '0) begin
                    w_next = ST_GAP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= 2'd0;
            r_last     <= 2'd2;
            r_color    <= 3'd0;
            r_hold_cnt <= '0;
        end else if (w_take) begin
            r_owner    <= w_win;
            r_color    <= w_sel_color;
            r_hold_cnt <= w_sel_hold;
        end else if (r_state == ST_SHOW) begin
            // Counter parks at zero; the SHOW->GAP transition handles the end.
            if (r_hold_cnt == '0) begin
                r_last <= r_owner;
            end else begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
        end
    end

`ifdef RGB_LED_SCHED_PWM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_pwm_on = (r_pwm_cnt < duty);
`else
    logic w_unused_duty;

    assign w_unused_duty = ^duty;
    assign w_pwm_on      = 1'b1;
`endif

    assign w_show         = (r_state == ST_SHOW);
    assign w_owner_onehot = 3'b001 << r_owner;

    assign grant     = w_show ? w_owner_onehot : 3'b000;
    assign done      = (r_state == ST_GAP) ? w_owner_onehot : 3'b000;
    assign busy      = w_show;
    assign led_green = r_color[0] & w_show & w_pwm_on;
    assign led_red   = r_color[1] & w_show & w_pwm_on;
    assign led_blue  = r_color[2] & w_show & w_pwm_on;

endmodule

`default_nettype wire
